// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rv64_mem_pkg
// Shared definitions for the unified-memory port arbiter: arbiter FSM state
// encoding, requester identifiers and default bus widths.
// ----------------------------------------------------------------------------
package rv64_mem_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 64;
    localparam int DEF_INST_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ_IF = 1'b0;
    localparam req_id_t REQ_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the three buses seen by the arbiter: instruction-fetch port,
// data-memory port and the single-port memory itself.
//   slave  : arbiter view (requests and memory read data in, grants/valids,
//            responses and memory strobes out)
//   master : core / memory view (the opposite directions)
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if
    import rv64_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int INST_WIDTH = DEF_INST_WIDTH
);

    // Instruction-fetch port
    logic                  in_IF_req;
    logic [ADDR_WIDTH-1:0] in_IF_addr;
    logic                  out_IF_gnt;
    logic                  out_IF_valid;
    logic [INST_WIDTH-1:0] out_inst;

    // Data-memory port
    logic                  in_DM_req;
    logic                  in_DM_wr_en;
    logic [ADDR_WIDTH-1:0] in_DM_addr;
    logic [DATA_WIDTH-1:0] in_DM_wr_data;
    logic                  out_DM_gnt;
    logic                  out_DM_valid;
    logic [DATA_WIDTH-1:0] out_DM_data;

    // Unified memory
    logic                  out_mem_en;
    logic                  out_mem_wr_en;
    logic [ADDR_WIDTH-1:0] out_mem_addr;
    logic [DATA_WIDTH-1:0] out_mem_wr_data;
    logic [DATA_WIDTH-1:0] in_mem_rd_data;

    modport slave (
        input  in_IF_req, in_IF_addr,
        input  in_DM_req, in_DM_wr_en, in_DM_addr, in_DM_wr_data,
        input  in_mem_rd_data,
        output out_IF_gnt, out_IF_valid, out_inst,
        output out_DM_gnt, out_DM_valid, out_DM_data,
        output out_mem_en, out_mem_wr_en, out_mem_addr, out_mem_wr_data
    );

    modport master (
        output in_IF_req, in_IF_addr,
        output in_DM_req, in_DM_wr_en, in_DM_addr, in_DM_wr_data,
        output in_mem_rd_data,
        input  out_IF_gnt, out_IF_valid, out_inst,
        input  out_DM_gnt, out_DM_valid, out_DM_data,
        input  out_mem_en, out_mem_wr_en, out_mem_addr, out_mem_wr_data
    );

endinterface

// File: rtl/mem_port_arbiter_prio.sv
// ----------------------------------------------------------------------------
// mem_arb_prio
// Winner selection between fetch and data requests plus the saturating
// fetch-starvation counter.
//   in_Clk, in_Rst_N : clock, asynchronous active-low reset
//   i_arb_en         : arbiter is in IDLE and may grant this cycle
//   i_if_req         : fetch request
//   i_dm_req         : data request
//   o_gnt_valid      : a grant is issued this cycle
//   o_winner         : REQ_IF / REQ_DM, meaningful when o_gnt_valid
// ----------------------------------------------------------------------------
module mem_arb_prio
    import rv64_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic    in_Clk,
    input  logic    in_Rst_N,
    input  logic    i_arb_en,
    input  logic    i_if_req,
    input  logic    i_dm_req,
    output logic    o_gnt_valid,
    output req_id_t o_winner
);

    localparam int             CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_if_forced;

    // Data normally wins; fetch takes over only once it has lost
    // STARVE_LIMIT arbitrations in a row and is still asking.
    assign w_if_forced = (r_starve_cnt >= LIMIT_VAL) && i_if_req;
    assign o_winner    = (i_dm_req && !w_if_forced) ? REQ_DM : REQ_IF;
    assign o_gnt_valid = i_arb_en && (i_if_req || i_dm_req);

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            r_starve_cnt <= '0;
        end else if (i_arb_en) begin
            if (!i_if_req || (o_gnt_valid && o_winner == REQ_IF)) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt < LIMIT_VAL) begin
                // Fetch is waiting and data was granted.
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port, fixed-latency memory between the instruction-fetch
// port and the data-memory port, one transaction at a time.
//   in_Clk, in_Rst_N : clock, asynchronous active-low reset
//   bus (slave)      : fetch port (req/addr -> gnt/valid/inst),
//                      data port (req/wr_en/addr/wr_data -> gnt/valid/data),
//                      memory (en/wr_en/addr/wr_data -> rd_data)
// Read timing: gnt cycle 0, mem_en cycle 1, rd_data sampled at the end of
// cycle 1+MEM_LATENCY, valid in cycle 2+MEM_LATENCY. Writes: valid in cycle 2.
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import rv64_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int INST_WIDTH   = DEF_INST_WIDTH,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 in_Clk,
    input  logic                 in_Rst_N,
    mem_port_arbiter_if.slave    bus
);

    localparam int             LAT_W    = $clog2(MEM_LATENCY) + 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);

    arb_state_e            r_state;
    req_id_t               r_owner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wr_en;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic                  r_mem_en;
    logic                  r_mem_wr_en;
    logic                  r_if_valid;
    logic                  r_dm_valid;
    logic [INST_WIDTH-1:0] r_inst;
    logic [DATA_WIDTH-1:0] r_dm_data;

    logic                  w_arb_en;
    logic                  w_gnt_valid;
    req_id_t               w_winner;

    // Grants are combinational; gating with the reset input keeps every
    // output low while reset is held even if a request is present.
    assign w_arb_en = (r_state == IDLE) && in_Rst_N;

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .in_Clk      (in_Clk),
        .in_Rst_N    (in_Rst_N),
        .i_arb_en    (w_arb_en),
        .i_if_req    (bus.in_IF_req),
        .i_dm_req    (bus.in_DM_req),
        .o_gnt_valid (w_gnt_valid),
        .o_winner    (w_winner)
    );

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            r_state     <= IDLE;
            r_owner     <= REQ_IF;
            r_addr      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_lat_cnt   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_if_valid  <= 1'b0;
            r_dm_valid  <= 1'b0;
            r_inst      <= '0;
            r_dm_data   <= '0;
        end else begin
            // Strobes are single-cycle pulses raised on the transition
            // into the state that owns them.
            r_mem_en    <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_if_valid  <= 1'b0;
            r_dm_valid  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_owner  <= w_winner;
                        r_mem_en <= 1'b1;
                        r_state  <= ISSUE;
                        if (w_winner == REQ_DM) begin
                            r_addr      <= bus.in_DM_addr;
                            r_wr_en     <= bus.in_DM_wr_en;
                            r_wr_data   <= bus.in_DM_wr_data;
                            r_mem_wr_en <= bus.in_DM_wr_en;
                        end else begin
                            r_addr    <= bus.in_IF_addr;
                            r_wr_en   <= 1'b0;
                            r_wr_data <= '0;
                        end
                    end
                end

                ISSUE: begin
                    if (r_wr_en) begin
                        // Only the data port can write.
                        r_dm_valid <= 1'b1;
                        r_state    <= RESP;
                    end else begin
                        r_lat_cnt <= LAT_LOAD;
                        r_state   <= WAIT;
                    end
                end

                WAIT: begin
                    if (r_lat_cnt == '0) begin
                        if (r_owner == REQ_IF) begin
                            r_inst     <= bus.in_mem_rd_data[INST_WIDTH-1:0];
                            r_if_valid <= 1'b1;
                        end else begin
                            r_dm_data  <= bus.in_mem_rd_data;
                            r_dm_valid <= 1'b1;
                        end
                        r_state <= RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end
                end

                RESP: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_IF_gnt      = w_gnt_valid && (w_winner == REQ_IF);
    assign bus.out_DM_gnt      = w_gnt_valid && (w_winner == REQ_DM);
    assign bus.out_IF_valid    = r_if_valid;
    assign bus.out_DM_valid    = r_dm_valid;
    assign bus.out_inst        = r_inst;
    assign bus.out_DM_data     = r_dm_data;
    assign bus.out_mem_en      = r_mem_en;
    assign bus.out_mem_wr_en   = r_mem_wr_en;
    assign bus.out_mem_addr    = r_addr;
    assign bus.out_mem_wr_data = r_wr_data;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and data-memory port.
- Allows the RV64IF core to run against a single physical memory instead of separate IMem/DMem instances.
- Serialises requests, one outstanding transaction at a time.
- Data accesses have fixed priority, with a starvation guard for fetch, and read latency is tracked against a fixed-latency memory.

Parameters:
- DATA_WIDTH, 64, data bus width.
- ADDR_WIDTH, 64, address width.
- INST_WIDTH, 32, instruction width; the low INST_WIDTH bits of read data are returned to fetch.
- MEM_LATENCY, 2, cycles from the mem_en cycle to valid in_mem_rd_data; minimum 1.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch wins.

Ports:
- in_Clk  in  1  clock, rising edge.
- in_Rst_N  in  1  asynchronous active-low reset.
- in_IF_req  in  1  fetch request.
- in_IF_addr  in  ADDR_WIDTH  fetch address.
- out_IF_gnt  out  1  fetch request accepted (1-cycle pulse).
- out_IF_valid  out  1  out_inst valid (1-cycle pulse).
- out_inst  out  INST_WIDTH  fetched instruction.
- in_DM_req  in  1  data request.
- in_DM_wr_en  in  1  1 = write, 0 = read.
- in_DM_addr  in  ADDR_WIDTH  data address.
- in_DM_wr_data  in  DATA_WIDTH  write data.
- out_DM_gnt  out  1  data request accepted (1-cycle pulse).
- out_DM_valid  out  1  read data valid / write done (1-cycle pulse).
- out_DM_data  out  DATA_WIDTH  read data.
- out_mem_en  out  1  memory access strobe.
- out_mem_wr_en  out  1  memory write enable.
- out_mem_addr  out  ADDR_WIDTH  memory address.
- out_mem_wr_data  out  DATA_WIDTH  memory write data.
- in_mem_rd_data  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset: in_Rst_N low asynchronously forces state IDLE and clears the starvation counter and latency counter. All outputs are 0, including out_inst and out_DM_data.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, pick the winner. DM wins unless the starvation count is >= STARVE_LIMIT and IF_req is high.
  - Assert the winner's gnt combinationally in this cycle.
  - Register addr, wr_en and wr_data (wr_en forced 0 for IF), then go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE: out_mem_en = 1 for exactly one cycle, with the registered signals. A write goes to RESP; a read loads the latency counter with MEM_LATENCY-1 and goes to WAIT.
- WAIT: decrement each cycle. At 0, capture in_mem_rd_data into out_inst (low INST_WIDTH bits) or out_DM_data, then go to RESP.
  - The capture edge is exactly MEM_LATENCY cycles after the ISSUE cycle.
- RESP: the owner's valid = 1 for one cycle, then go to IDLE. The next grant comes no earlier than the cycle after RESP.
- Read latency:
  - gnt in cycle 0, mem_en in cycle 1, data sampled at the end of cycle 1+MEM_LATENCY, valid in cycle 2+MEM_LATENCY.
  - With the default of 2: valid in cycle 4.
- Write latency: gnt in cycle 0, mem_en in cycle 1, out_DM_valid in cycle 2. out_DM_data is unchanged.
- Output data holds its value until the next capture for the same requester.
- Starvation counter:
  - Increments when DM is granted while IF_req is high.
  - Clears when IF is granted or IF_req is low in IDLE.
  - Saturates at STARVE_LIMIT.
- Request rules:
  - A requester holds req, addr and data stable until gnt.
  - Dropping req before gnt withdraws the request with no side effect.
  - req high outside IDLE is ignored until IDLE.
  - After gnt, the requester may change inputs freely.
- Simultaneous requests in IDLE: only one gnt per cycle. The loser keeps waiting.
- No address alignment or range checks; addresses pass through unchanged.
- Reset mid-transaction aborts it: no valid is produced, and mem_en is deasserted immediately.

Decomposition:
- Shared package rv64_mem_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - requester ID constants REQ_IF = 0, REQ_DM = 1
  - default width constants (64/32)
- One sub-module, mem_arb_prio: winner selection plus the saturating starvation counter (registered, same clock/reset). The FSM and latency counter stay in the top module.

Test Plan:
- Single IF read, addr 0x100, memory returns 0x00000013_00A00093 -> out_IF_gnt in cycle 0, out_mem_en in cycle 1, out_IF_valid in cycle 4, out_inst = 0x00A00093.
- DM write, addr 0x2000, data 0xDEADBEEF_CAFEF00D -> out_mem_en = 1 and out_mem_wr_en = 1 in cycle 1 with that addr/data; out_DM_valid in cycle 2; out_DM_data unchanged.
- IF and DM requests in the same cycle -> DM granted first; IF granted in the first IDLE after DM's RESP; exactly one gnt per cycle.
- DM held continuously high with IF high, STARVE_LIMIT = 4 -> 4 DM grants, then an IF grant, then DM again.
- Reset asserted in WAIT (cycle 2 of a read) -> all outputs 0 asynchronously; no out_IF_valid after release; the next request is served normally from IDLE.
- MEM_LATENCY = 1 build, DM read of 0x8 returning 0x1234 -> out_DM_valid in cycle 3, out_DM_data = 0x1234.
